// File: rtl/sm83_bus_responder_pkg.sv
// rtl/sm83_bus_responder_pkg.sv - shared types and address map for the SM83 bus responder
package sm83_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_INT      = 2'd1,
      ST_EXT_WAIT = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   localparam logic [15:0] ADDR_IF      = 16'hFF0F;
   localparam logic [15:0] ADDR_BOOTOFF = 16'hFF50;
   localparam logic [15:0] ADDR_IE      = 16'hFFFF;
   localparam logic [15:0] HRAM_BASE    = 16'hFF80;

   localparam int IF_W = 5;

   // The top 128-byte page is HRAM except its last byte, which is the core-owned IE register.
   function automatic logic is_hram(input logic [15:0] addr);
      return (addr[15:7] == HRAM_BASE[15:7]) && (addr != ADDR_IE);
   endfunction

   function automatic logic is_internal(input logic [15:0] addr);
      return (addr == ADDR_IF) || (addr == ADDR_BOOTOFF) || (addr[15:7] == HRAM_BASE[15:7]);
   endfunction

endpackage

// File: rtl/sm83_bus_responder_if.sv
// rtl/sm83_bus_responder_if.sv - core bus, interrupt and external-port signals of the responder
interface sm83_bus_responder_if
   import sm83_bus_pkg::*;
();

   logic [15:0]     A;
   logic            RD;
   logic            WR;
   logic            MREQ;
   logic [7:0]      D_WR;
   logic [7:0]      D_RD;
   logic            D_OE;
   logic            RDY;
   logic            MMIO_REQ;
   logic            IPL_REQ;
   logic [7:0]      CPU_IRQ_TRIG;
   logic [7:0]      CPU_IRQ_ACK;
   logic [IF_W-1:0] IRQ_SRC;
   logic            EXT_REQ;
   logic            EXT_WE;
   logic            EXT_IPL;
   logic [15:0]     EXT_A;
   logic [7:0]      EXT_WDATA;
   logic            EXT_ACK;
   logic [7:0]      EXT_RDATA;
   logic            BUS_TIMEOUT;

   modport slave (
      input  A, RD, WR, MREQ, D_WR, CPU_IRQ_ACK, IRQ_SRC, EXT_ACK, EXT_RDATA,
      output D_RD, D_OE, RDY, MMIO_REQ, IPL_REQ, CPU_IRQ_TRIG,
             EXT_REQ, EXT_WE, EXT_IPL, EXT_A, EXT_WDATA, BUS_TIMEOUT
   );

   modport master (
      output A, RD, WR, MREQ, D_WR, CPU_IRQ_ACK, IRQ_SRC, EXT_ACK, EXT_RDATA,
      input  D_RD, D_OE, RDY, MMIO_REQ, IPL_REQ, CPU_IRQ_TRIG,
             EXT_REQ, EXT_WE, EXT_IPL, EXT_A, EXT_WDATA, BUS_TIMEOUT
   );

endinterface

// File: rtl/sm83_irq_flags.sv
// rtl/sm83_irq_flags.sv - IF register: peripheral set pulses, core acknowledge and direct CPU write
module sm83_irq_flags
   import sm83_bus_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            wr_en,
   input  logic [IF_W-1:0] wr_data,
   input  logic [IF_W-1:0] ack,
   input  logic [IF_W-1:0] src,
   output logic [IF_W-1:0] flags
);

   logic [IF_W-1:0] flags_q;
   logic [IF_W-1:0] flags_d;

   // A new request always survives an acknowledge or write landing in the same cycle.
   always_comb begin
      flags_d = (flags_q & ~ack) | src;
      if (wr_en) begin
         flags_d = wr_data | src;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: rtl/sm83_bus_responder.sv
// rtl/sm83_bus_responder.sv - target side of the SM83 memory bus: IF, HRAM, boot-off and external forwarding
module sm83_bus_responder
   import sm83_bus_pkg::*;
#(
   parameter int EXT_TIMEOUT       = 16,
   parameter bit BOOT_VISIBLE_INIT = 1'b1
)(
   input  logic                 CLK,
   input  logic                 RESET,
   sm83_bus_responder_if.slave  bus
);

   localparam logic [7:0] CNT_LAST = 8'(EXT_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            rd_q, wr_q;
   logic [15:0]     addr_q, addr_d;
   logic            we_q, we_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      d_rd_q, d_rd_d;
   logic            d_oe_q, d_oe_d;
   logic            rdy_q, rdy_d;
   logic            ext_req_q, ext_req_d;
   logic            ext_we_q, ext_we_d;
   logic            ext_ipl_q, ext_ipl_d;
   logic [15:0]     ext_a_q, ext_a_d;
   logic [7:0]      ext_wdata_q, ext_wdata_d;
   logic            bus_timeout_q, bus_timeout_d;
   logic            boot_visible_q, boot_visible_d;

   logic            start;
   logic            ipl_req;
   logic            hram_we;
   logic            if_wr;
   logic [7:0]      int_rdata;
   logic [IF_W-1:0] if_flags;
   logic            unused_ack_hi;

   logic [7:0]      hram [0:126];

   assign start         = bus.MREQ & (bus.RD ^ bus.WR) & ~(rd_q | wr_q);
   assign ipl_req       = (bus.A[15:8] == 8'h00) && boot_visible_q;
   assign unused_ack_hi = ^bus.CPU_IRQ_ACK[7:5];

   sm83_irq_flags u_irq_flags (
      .CLK     (CLK),
      .RESET   (RESET),
      .wr_en   (if_wr),
      .wr_data (wdata_q[IF_W-1:0]),
      .ack     (bus.CPU_IRQ_ACK[IF_W-1:0]),
      .src     (bus.IRQ_SRC),
      .flags   (if_flags)
   );

   always_comb begin
      int_rdata = 8'hFF;
      if (addr_q == ADDR_IF) begin
         int_rdata = {3'b111, if_flags};
      end else if (is_hram(addr_q)) begin
         int_rdata = hram[addr_q[6:0]];
      end
   end

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      cnt_d          = cnt_q;
      d_rd_d         = d_rd_q;
      d_oe_d         = d_oe_q;
      rdy_d          = 1'b0;
      ext_req_d      = ext_req_q;
      ext_we_d       = ext_we_q;
      ext_ipl_d      = ext_ipl_q;
      ext_a_d        = ext_a_q;
      ext_wdata_d    = ext_wdata_q;
      bus_timeout_d  = 1'b0;
      boot_visible_d = boot_visible_q;
      hram_we        = 1'b0;
      if_wr          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = bus.A;
               we_d    = bus.WR;
               wdata_d = bus.D_WR;
               cnt_d   = 8'd0;
               if (is_internal(bus.A)) begin
                  state_d = ST_INT;
               end else begin
                  state_d     = ST_EXT_WAIT;
                  ext_req_d   = 1'b1;
                  ext_we_d    = bus.WR;
                  ext_ipl_d   = ipl_req;
                  ext_a_d     = bus.A;
                  ext_wdata_d = bus.D_WR;
               end
            end
         end

         ST_INT: begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
            if (we_q) begin
               hram_we = is_hram(addr_q);
               if_wr   = (addr_q == ADDR_IF);
               if ((addr_q == ADDR_BOOTOFF) && (wdata_q != 8'h00)) begin
                  boot_visible_d = 1'b0;
               end
            end else if (addr_q != ADDR_IE) begin
               d_rd_d = int_rdata;
               d_oe_d = 1'b1;
            end
         end

         ST_EXT_WAIT: begin
            // An ack in the last permitted cycle still completes the access normally.
            if (bus.EXT_ACK) begin
               state_d   = ST_DONE;
               rdy_d     = 1'b1;
               ext_req_d = 1'b0;
               if (!we_q) begin
                  d_rd_d = bus.EXT_RDATA;
                  d_oe_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = ST_DONE;
               rdy_d         = 1'b1;
               ext_req_d     = 1'b0;
               bus_timeout_d = 1'b1;
               if (!we_q) begin
                  d_rd_d = 8'hFF;
                  d_oe_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_DONE: begin
            if (!bus.RD) begin
               d_oe_d = 1'b0;
            end
            if (!bus.RD && !bus.WR) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q        <= ST_IDLE;
         rd_q           <= 1'b0;
         wr_q           <= 1'b0;
         addr_q         <= 16'h0000;
         we_q           <= 1'b0;
         wdata_q        <= 8'h00;
         cnt_q          <= 8'd0;
         d_rd_q         <= 8'hFF;
         d_oe_q         <= 1'b0;
         rdy_q          <= 1'b0;
         ext_req_q      <= 1'b0;
         ext_we_q       <= 1'b0;
         ext_ipl_q      <= 1'b0;
         ext_a_q        <= 16'h0000;
         ext_wdata_q    <= 8'h00;
         bus_timeout_q  <= 1'b0;
         boot_visible_q <= BOOT_VISIBLE_INIT;
      end else begin
         state_q        <= state_d;
         rd_q           <= bus.RD;
         wr_q           <= bus.WR;
         addr_q         <= addr_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         cnt_q          <= cnt_d;
         d_rd_q         <= d_rd_d;
         d_oe_q         <= d_oe_d;
         rdy_q          <= rdy_d;
         ext_req_q      <= ext_req_d;
         ext_we_q       <= ext_we_d;
         ext_ipl_q      <= ext_ipl_d;
         ext_a_q        <= ext_a_d;
         ext_wdata_q    <= ext_wdata_d;
         bus_timeout_q  <= bus_timeout_d;
         boot_visible_q <= boot_visible_d;
      end
   end

   // HRAM keeps its contents across reset.
   always_ff @(posedge CLK) begin
      if (hram_we) begin
         hram[addr_q[6:0]] <= wdata_q;
      end
   end

   assign bus.D_RD         = d_rd_q;
   assign bus.D_OE         = d_oe_q;
   assign bus.RDY          = rdy_q;
   assign bus.MMIO_REQ     = (bus.A[15:9] == 7'h7F);
   assign bus.IPL_REQ      = ipl_req;
   assign bus.CPU_IRQ_TRIG = {3'b000, if_flags};
   assign bus.EXT_REQ      = ext_req_q;
   assign bus.EXT_WE       = ext_we_q;
   assign bus.EXT_IPL      = ext_ipl_q;
   assign bus.EXT_A        = ext_a_q;
   assign bus.EXT_WDATA    = ext_wdata_q;
   assign bus.BUS_TIMEOUT  = bus_timeout_q;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// tb/tb_sm83_bus_responder.sv - directed self-checking bench for sm83_bus_responder
module tb_sm83_bus_responder;
   import sm83_bus_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   sm83_bus_responder_if bus();

   sm83_bus_responder #(
      .EXT_TIMEOUT       (16),
      .BOOT_VISIBLE_INIT (1'b1)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Observations of the most recent access; r_rdy_at counts the strobe cycle as cycle 1.
   int          r_rdy_at, r_rdy_cnt, r_req_cyc, r_to_cnt;
   logic [7:0]  r_rd;
   logic        r_oe, r_ipl, r_we;
   logic [15:0] r_ext_a;

   task automatic access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                         input int ack_after, input logic [7:0] ext_rd);
      @(negedge clk);
      bus.A = a; bus.D_WR = wd; bus.RD = ~we; bus.WR = we; bus.MREQ = 1'b1; bus.EXT_RDATA = ext_rd;
      r_rdy_at = -1; r_rdy_cnt = 0; r_req_cyc = 0; r_to_cnt = 0;
      r_rd = 8'hxx; r_oe = 1'bx; r_ipl = 1'bx; r_we = 1'bx; r_ext_a = 16'hxxxx;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (bus.RDY) begin
            r_rdy_cnt++;
            if (r_rdy_at < 0) begin r_rdy_at = c + 1; r_rd = bus.D_RD; r_oe = bus.D_OE; end
         end
         if (bus.EXT_REQ) begin
            if (r_req_cyc == 0) begin r_ipl = bus.EXT_IPL; r_we = bus.EXT_WE; r_ext_a = bus.EXT_A; end
            r_req_cyc++;
         end
         if (bus.BUS_TIMEOUT) r_to_cnt++;
         bus.EXT_ACK = (ack_after > 0) && bus.EXT_REQ && (r_req_cyc == ack_after);
      end
   endtask

   task automatic release_bus();
      @(negedge clk);
      bus.RD = 1'b0; bus.WR = 1'b0; bus.MREQ = 1'b0; bus.EXT_ACK = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.A = 16'h0000; bus.RD = 0; bus.WR = 0; bus.MREQ = 0; bus.D_WR = 0;
      bus.CPU_IRQ_ACK = 0; bus.IRQ_SRC = 0; bus.EXT_ACK = 0; bus.EXT_RDATA = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (bus.D_RD !== 8'hFF) begin n_fail++; $display("FAIL rst_d_rd: got %h expected ff", bus.D_RD); end
      n_tests++; if (bus.D_OE !== 1'b0) begin n_fail++; $display("FAIL rst_d_oe: got %b expected 0", bus.D_OE); end
      n_tests++; if (bus.RDY !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b expected 0", bus.RDY); end
      n_tests++; if (bus.EXT_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_ext_req: got %b expected 0", bus.EXT_REQ); end
      n_tests++; if (bus.EXT_A !== 16'h0000) begin n_fail++; $display("FAIL rst_ext_a: got %h expected 0000", bus.EXT_A); end
      n_tests++; if (bus.BUS_TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", bus.BUS_TIMEOUT); end
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h00) begin n_fail++; $display("FAIL rst_trig: got %h expected 00", bus.CPU_IRQ_TRIG); end
      n_tests++; if (bus.IPL_REQ !== 1'b1) begin n_fail++; $display("FAIL rst_ipl: got %b expected 1", bus.IPL_REQ); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hram();
      access(16'hFF80, 1'b1, 8'h5A, 0, 8'h00);
      n_tests++; if (r_rdy_at !== 3) begin n_fail++; $display("FAIL hram_wr_lat: got %0d expected 3", r_rdy_at); end
      n_tests++; if (r_rdy_cnt !== 1) begin n_fail++; $display("FAIL hram_wr_rdy_cnt: got %0d expected 1", r_rdy_cnt); end
      n_tests++; if (r_req_cyc !== 0) begin n_fail++; $display("FAIL hram_wr_no_ext: got %0d expected 0", r_req_cyc); end
      release_bus();
      access(16'hFF80, 1'b0, 8'h00, 0, 8'h00);
      n_tests++; if (r_rdy_at !== 3) begin n_fail++; $display("FAIL hram_rd_lat: got %0d expected 3", r_rdy_at); end
      n_tests++; if (r_rd !== 8'h5A) begin n_fail++; $display("FAIL hram_rd_data: got %h expected 5a", r_rd); end
      n_tests++; if (bus.D_OE !== 1'b1) begin n_fail++; $display("FAIL hram_oe_hold: got %b expected 1", bus.D_OE); end
      release_bus();
      n_tests++; if (bus.D_OE !== 1'b0) begin n_fail++; $display("FAIL hram_oe_drop: got %b expected 0", bus.D_OE); end
      n_tests++; if (bus.D_RD !== 8'h5A) begin n_fail++; $display("FAIL hram_d_rd_hold: got %h expected 5a", bus.D_RD); end
      access(16'hFFFE, 1'b1, 8'hA5, 0, 8'h00);
      release_bus();
      access(16'hFFFE, 1'b0, 8'h00, 0, 8'h00);
      n_tests++; if (r_rd !== 8'hA5) begin n_fail++; $display("FAIL hram_top_data: got %h expected a5", r_rd); end
      release_bus();
      n_tests++; if (bus.MMIO_REQ !== 1'b1) begin n_fail++; $display("FAIL mmio_ff: got %b expected 1", bus.MMIO_REQ); end
      bus.A = 16'hFDFF; #1;
      n_tests++; if (bus.MMIO_REQ !== 1'b0) begin n_fail++; $display("FAIL mmio_fd: got %b expected 0", bus.MMIO_REQ); end
   endtask

   task automatic test_irq();
      @(negedge clk); bus.IRQ_SRC = 5'b00100;
      @(negedge clk); bus.IRQ_SRC = 5'b00000;
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h04) begin n_fail++; $display("FAIL irq_set: got %h expected 04", bus.CPU_IRQ_TRIG); end
      bus.CPU_IRQ_ACK = 8'h04; bus.IRQ_SRC = 5'b00100;
      @(negedge clk); bus.CPU_IRQ_ACK = 8'h00; bus.IRQ_SRC = 5'b00000;
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h04) begin n_fail++; $display("FAIL irq_set_wins: got %h expected 04", bus.CPU_IRQ_TRIG); end
      bus.CPU_IRQ_ACK = 8'h04;
      @(negedge clk); bus.CPU_IRQ_ACK = 8'h00;
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h00) begin n_fail++; $display("FAIL irq_ack: got %h expected 00", bus.CPU_IRQ_TRIG); end
      access(ADDR_IF, 1'b0, 8'h00, 0, 8'h00);
      n_tests++; if (r_rd !== 8'hE0) begin n_fail++; $display("FAIL if_rd_zero: got %h expected e0", r_rd); end
      release_bus();
      access(ADDR_IF, 1'b1, 8'h13, 0, 8'h00);
      release_bus();
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h13) begin n_fail++; $display("FAIL if_wr: got %h expected 13", bus.CPU_IRQ_TRIG); end
      access(ADDR_IF, 1'b0, 8'h00, 0, 8'h00);
      n_tests++; if (r_rd !== 8'hF3) begin n_fail++; $display("FAIL if_rd_back: got %h expected f3", r_rd); end
      release_bus();
      bus.CPU_IRQ_ACK = 8'hE0;
      @(negedge clk); bus.CPU_IRQ_ACK = 8'h00;
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h13) begin n_fail++; $display("FAIL irq_ack_hi_ignored: got %h expected 13", bus.CPU_IRQ_TRIG); end
      bus.CPU_IRQ_ACK = 8'h1F;
      @(negedge clk); bus.CPU_IRQ_ACK = 8'h00;
      n_tests++; if (bus.CPU_IRQ_TRIG !== 8'h00) begin n_fail++; $display("FAIL irq_ack_all: got %h expected 00", bus.CPU_IRQ_TRIG); end
   endtask

   task automatic test_boot();
      bus.A = 16'h0010; #1;
      n_tests++; if (bus.IPL_REQ !== 1'b1) begin n_fail++; $display("FAIL ipl_visible: got %b expected 1", bus.IPL_REQ); end
      access(16'h0010, 1'b0, 8'h00, 1, 8'h77);
      n_tests++; if (r_ipl !== 1'b1) begin n_fail++; $display("FAIL ext_ipl_set: got %b expected 1", r_ipl); end
      n_tests++; if (r_rd !== 8'h77) begin n_fail++; $display("FAIL boot_rd: got %h expected 77", r_rd); end
      release_bus();
      access(ADDR_BOOTOFF, 1'b1, 8'h01, 0, 8'h00);
      release_bus();
      bus.A = 16'h0010; #1;
      n_tests++; if (bus.IPL_REQ !== 1'b0) begin n_fail++; $display("FAIL ipl_hidden: got %b expected 0", bus.IPL_REQ); end
      access(16'h0010, 1'b0, 8'h00, 1, 8'h77);
      n_tests++; if (r_ipl !== 1'b0) begin n_fail++; $display("FAIL ext_ipl_clr: got %b expected 0", r_ipl); end
      release_bus();
      access(ADDR_BOOTOFF, 1'b1, 8'h00, 0, 8'h00);
      release_bus();
      bus.A = 16'h0010; #1;
      n_tests++; if (bus.IPL_REQ !== 1'b0) begin n_fail++; $display("FAIL ipl_wr0_sticky: got %b expected 0", bus.IPL_REQ); end
      access(ADDR_BOOTOFF, 1'b0, 8'h00, 0, 8'h00);
      n_tests++; if (r_rd !== 8'hFF) begin n_fail++; $display("FAIL bootoff_rd: got %h expected ff", r_rd); end
      release_bus();
   endtask

   task automatic test_ext_read();
      access(16'hC000, 1'b0, 8'h00, 3, 8'h3C);
      n_tests++; if (r_rdy_at !== 5) begin n_fail++; $display("FAIL ext_rd_lat: got %0d expected 5", r_rdy_at); end
      n_tests++; if (r_rdy_cnt !== 1) begin n_fail++; $display("FAIL ext_rd_rdy_cnt: got %0d expected 1", r_rdy_cnt); end
      n_tests++; if (r_to_cnt !== 0) begin n_fail++; $display("FAIL ext_rd_no_to: got %0d expected 0", r_to_cnt); end
      n_tests++; if (r_rd !== 8'h3C) begin n_fail++; $display("FAIL ext_rd_data: got %h expected 3c", r_rd); end
      n_tests++; if (r_req_cyc !== 3) begin n_fail++; $display("FAIL ext_rd_req_cyc: got %0d expected 3", r_req_cyc); end
      n_tests++; if (r_ext_a !== 16'hC000) begin n_fail++; $display("FAIL ext_rd_addr: got %h expected c000", r_ext_a); end
      n_tests++; if (r_we !== 1'b0) begin n_fail++; $display("FAIL ext_rd_we: got %b expected 0", r_we); end
      release_bus();
      access(16'hC001, 1'b0, 8'h00, 16, 8'h99);
      n_tests++; if (r_to_cnt !== 0) begin n_fail++; $display("FAIL last_ack_no_to: got %0d expected 0", r_to_cnt); end
      n_tests++; if (r_rd !== 8'h99) begin n_fail++; $display("FAIL last_ack_data: got %h expected 99", r_rd); end
      n_tests++; if (r_rdy_at !== 18) begin n_fail++; $display("FAIL last_ack_lat: got %0d expected 18", r_rdy_at); end
      release_bus();
   endtask

   task automatic test_timeout();
      access(16'hC000, 1'b1, 8'h11, 0, 8'h00);
      n_tests++; if (r_req_cyc !== 16) begin n_fail++; $display("FAIL to_wr_req_cyc: got %0d expected 16", r_req_cyc); end
      n_tests++; if (r_to_cnt !== 1) begin n_fail++; $display("FAIL to_wr_pulse: got %0d expected 1", r_to_cnt); end
      n_tests++; if (r_rdy_cnt !== 1) begin n_fail++; $display("FAIL to_wr_rdy_cnt: got %0d expected 1", r_rdy_cnt); end
      n_tests++; if (r_rdy_at !== 18) begin n_fail++; $display("FAIL to_wr_lat: got %0d expected 18", r_rdy_at); end
      n_tests++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL to_wr_we: got %b expected 1", r_we); end
      n_tests++; if (bus.EXT_WDATA !== 8'h11) begin n_fail++; $display("FAIL to_wr_wdata: got %h expected 11", bus.EXT_WDATA); end
      release_bus();
      access(16'hC000, 1'b0, 8'h00, 0, 8'h55);
      n_tests++; if (r_rd !== 8'hFF) begin n_fail++; $display("FAIL to_rd_data: got %h expected ff", r_rd); end
      n_tests++; if (r_oe !== 1'b1) begin n_fail++; $display("FAIL to_rd_oe: got %b expected 1", r_oe); end
      n_tests++; if (r_to_cnt !== 1) begin n_fail++; $display("FAIL to_rd_pulse: got %0d expected 1", r_to_cnt); end
      release_bus();
   endtask

   task automatic test_ie();
      access(ADDR_IE, 1'b0, 8'h00, 0, 8'h00);
      n_tests++; if (r_rdy_at !== 3) begin n_fail++; $display("FAIL ie_lat: got %0d expected 3", r_rdy_at); end
      n_tests++; if (r_oe !== 1'b0) begin n_fail++; $display("FAIL ie_oe: got %b expected 0", r_oe); end
      n_tests++; if (r_req_cyc !== 0) begin n_fail++; $display("FAIL ie_no_ext: got %0d expected 0", r_req_cyc); end
      release_bus();
   endtask

   task automatic test_both_strobes();
      int rdy_seen = 0;
      int req_seen = 0;
      @(negedge clk);
      bus.A = 16'hC000; bus.RD = 1'b1; bus.WR = 1'b1; bus.MREQ = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.RDY) rdy_seen++;
         if (bus.EXT_REQ) req_seen++;
      end
      n_tests++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL both_no_rdy: got %0d expected 0", rdy_seen); end
      n_tests++; if (req_seen !== 0) begin n_fail++; $display("FAIL both_no_req: got %0d expected 0", req_seen); end
      release_bus();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.A = 16'hC000; bus.RD = 1'b1; bus.WR = 1'b0; bus.MREQ = 1'b1; bus.EXT_ACK = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (bus.EXT_REQ !== 1'b1) begin n_fail++; $display("FAIL mid_req_up: got %b expected 1", bus.EXT_REQ); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if (bus.EXT_REQ !== 1'b0) begin n_fail++; $display("FAIL mid_req_async: got %b expected 0", bus.EXT_REQ); end
      @(negedge clk);
      bus.RD = 1'b0; bus.MREQ = 1'b0; bus.A = 16'h0000;
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if (bus.IPL_REQ !== 1'b1) begin n_fail++; $display("FAIL mid_boot_restored: got %b expected 1", bus.IPL_REQ); end
      n_tests++; if (bus.RDY !== 1'b0) begin n_fail++; $display("FAIL mid_rdy: got %b expected 0", bus.RDY); end
   endtask

   initial begin
      test_reset();
      test_hram();
      test_irq();
      test_boot();
      test_ext_read();
      test_timeout();
      test_ie();
      test_both_strobes();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sm83_bus_responder.md
Name: sm83_bus_responder

Overview:
- Target side of the SM83 core's memory interface: answers the core's RD/WR/MREQ cycles on A/D.
- Generates the MMIO_REQ and IPL_REQ decode inputs the core consumes.
- Owns the IF (interrupt-flag) register at 0xFF0F, which drives CPU_IRQ_TRIG and clears on CPU_IRQ_ACK. Also owns HRAM (0xFF80–0xFFFE) and the boot-ROM disable register (0xFF50).
- Forwards all other accesses to an external memory/peripheral port through a req/ack handshake with a timeout.

Parameters:
- EXT_TIMEOUT, 16, max cycles spent in EXT_WAIT before the access is aborted (legal range 1..255).
- BOOT_VISIBLE_INIT, 1, reset value of the boot-ROM-visible flag.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- A  in  16  address from the core.
- RD  in  1  read strobe from the core.
- WR  in  1  write strobe from the core.
- MREQ  in  1  memory request from the core (qualifies RD/WR).
- D_WR  in  8  write data from the core.
- D_RD  out  8  read data to the core.
- D_OE  out  1  read-data drive enable.
- RDY  out  1  access-complete pulse.
- MMIO_REQ  out  1  combinational, A[15:9]==7'h7F.
- IPL_REQ  out  1  combinational, A[15:8]==0 && boot_visible.
- CPU_IRQ_TRIG  out  8  {3'b000, IF[4:0]}.
- CPU_IRQ_ACK  in  8  one-hot IF clear from the core.
- IRQ_SRC  in  5  peripheral interrupt set pulses.
- EXT_REQ  out  1  external request.
- EXT_WE  out  1  external write enable.
- EXT_IPL  out  1  external access targets the boot ROM.
- EXT_A  out  16  external address.
- EXT_WDATA  out  8  external write data.
- EXT_ACK  in  1  external acknowledge.
- EXT_RDATA  in  8  external read data.
- BUS_TIMEOUT  out  1  one-cycle pulse on an aborted external access.

Behaviour:

Reset values (all outputs):
- D_RD=8'hFF, D_OE=0, RDY=0, EXT_REQ=0, EXT_WE=0, EXT_IPL=0, EXT_A=0, EXT_WDATA=0, BUS_TIMEOUT=0.
- IF=0; boot_visible=BOOT_VISIBLE_INIT; FSM=IDLE; timeout counter=0. HRAM contents are not reset.
- RESET asserted mid-access drops EXT_REQ immediately (asynchronously) and abandons the access.

Access start:
- Registered strobe edge: start = MREQ & (RD^WR) & ~(RD_q|WR_q), evaluated in IDLE only.
- RD&WR both high: no access starts, no RDY.
- A, D_WR and the direction are captured at start.

FSM states: IDLE, INT, EXT_WAIT, DONE.
- IDLE -> INT when the captured address is 0xFF0F, 0xFF50, 0xFF80–0xFFFE or 0xFFFF.
- IDLE -> EXT_WAIT otherwise. EXT_REQ=1 while in EXT_WAIT; EXT_IPL = IPL_REQ at start.
- INT -> DONE after exactly 1 cycle. Read data and write effects are applied in INT.
- EXT_WAIT -> DONE when EXT_ACK=1. Read data is EXT_RDATA; EXT_REQ falls the same edge.
- EXT_WAIT -> DONE when the counter reaches EXT_TIMEOUT-1 without an ack. D_RD=8'hFF, writes are dropped, BUS_TIMEOUT pulses. If EXT_ACK arrives in that final cycle, the ack wins and there is no timeout.
- DONE: RDY=1 for exactly one cycle. D_OE=1 from DONE until RD falls (reads only, never for 0xFFFF). Return to IDLE once RD and WR are both low. D_RD holds its value until the next read completes.

Latency (strobe edge to RDY):
- Internal targets: 3 cycles (edge register, INT, DONE).
- External targets: 2 cycles plus ack wait.

Internal register behaviour:
- 0xFF0F read returns {3'b111, IF}.
- 0xFF0F write: IF_next = D_WR[4:0] | IRQ_SRC.
- Otherwise each cycle: IF_next = (IF & ~CPU_IRQ_ACK[4:0]) | IRQ_SRC. Set wins over ack in the same cycle. CPU_IRQ_ACK[7:5] is ignored.
- 0xFF50 write of a nonzero value clears boot_visible. It stays clear until RESET; writing 0 has no effect. 0xFF50 reads return 8'hFF.
- HRAM: 127 bytes indexed by A[6:0]. Index 127 is never reached because 0xFFFF is decoded as IE.
- 0xFFFF (IE) lives in the core: the responder completes with RDY, has no write effect, and keeps D_OE=0.

Decomposition:
- Package sm83_bus_pkg holds:
  - FSM state enum;
  - address constants ADDR_IF=16'hFF0F, ADDR_BOOTOFF=16'hFF50, ADDR_IE=16'hFFFF, HRAM_BASE=16'hFF80;
  - the IF width constant (5).
- One sub-module, sm83_irq_flags: holds the IF register plus the set/ack/write merge, and is instantiated once.

Test Plan:
- RESET, then RD of 0xFF80 after a WR of 8'h5A to 0xFF80 -> RDY 3 cycles after each strobe edge; D_RD=8'h5A, D_OE=1 until RD falls.
- IRQ_SRC=5'b00100 pulse -> CPU_IRQ_TRIG=8'h04. Then CPU_IRQ_ACK=8'h04 together with IRQ_SRC=5'b00100 -> IF stays 5'b00100; ACK alone next -> IF=0. Read 0xFF0F -> 8'hE0.
- Read 0x0010 with boot visible -> IPL_REQ=1, EXT_IPL=1. Write 8'h01 to 0xFF50 -> IPL_REQ=0 on the next 0x0010 access. Write 8'h00 afterwards -> stays 0.
- External read of 0xC000 with EXT_ACK after 3 cycles carrying EXT_RDATA=8'h3C -> D_RD=8'h3C, RDY once, no BUS_TIMEOUT.
- External write of 0xC000, EXT_ACK never arrives -> EXT_REQ high for exactly 16 cycles, then BUS_TIMEOUT pulse and RDY. Read variant returns D_RD=8'hFF.
- RESET asserted during EXT_WAIT -> EXT_REQ=0 without waiting for a clock edge. RD and WR high together -> no RDY, no EXT_REQ.
